// File: rtl/de2_115_key_debounce_if.sv
// rtl/de2_115_key_debounce_if.sv - key pins and debounced key outputs bundle
`timescale 1ns/1ps
interface de2_115_key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_out;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_press;

    modport master (
        output key_raw,
        input  key_out,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  key_raw,
        output key_out,
        output press_pulse,
        output release_pulse,
        output long_press
    );
endinterface

// File: rtl/de2_115_key_debounce.sv
// rtl/de2_115_key_debounce.sv - per-key synchroniser, debouncer and press classifier
`timescale 1ns/1ps
module de2_115_key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic                    clk,
    input  logic                    reset_n,
    de2_115_key_debounce_if.slave   bus
);
    localparam logic             REL_LVL  = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    logic [NUM_KEYS-1:0] s1_q, s1_d;
    logic [NUM_KEYS-1:0] s2_q, s2_d;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] key_out_q, key_out_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    state_e              state_q [NUM_KEYS];
    state_e              state_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

    assign pressed = s2_q ^ {NUM_KEYS{REL_LVL}};

    always_comb begin
        s1_d      = bus.key_raw;
        s2_d      = s1_q;
        key_out_d = key_out_q;
        long_d    = long_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                RELEASED: begin
                    if (pressed[k]) begin
                        state_d[k] = PRESS_WAIT;
                        cnt_d[k]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed[k]) begin
                        state_d[k] = RELEASED;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == DEB_CNT) begin
                        state_d[k]   = PRESSED;
                        key_out_d[k] = ~REL_LVL;
                        press_d[k]   = 1'b1;
                        cnt_d[k]     = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    // The single counter switches from hold count to release debounce count here.
                    if (!pressed[k]) begin
                        state_d[k] = RELEASE_WAIT;
                        cnt_d[k]   = CNT_ONE;
                    end else if (cnt_q[k] != HOLD_CNT) begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                        if (cnt_q[k] + CNT_ONE == HOLD_CNT) begin
                            long_d[k] = 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed keeps the key down without a second press strobe.
                    if (pressed[k]) begin
                        state_d[k] = PRESSED;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == DEB_CNT) begin
                        state_d[k]   = RELEASED;
                        key_out_d[k] = REL_LVL;
                        release_d[k] = 1'b1;
                        long_d[k]    = 1'b0;
                        cnt_d[k]     = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = RELEASED;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= {NUM_KEYS{REL_LVL}};
            s2_q      <= {NUM_KEYS{REL_LVL}};
            key_out_q <= {NUM_KEYS{REL_LVL}};
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    assign bus.key_out       = key_out_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
endmodule

// File: tb/tb_de2_115_key_debounce.sv
// tb/tb_de2_115_key_debounce.sv - scoreboard bench for the key debouncer
`timescale 1ns/1ps
module tb_de2_115_key_debounce;
    localparam int NK   = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 32;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    de2_115_key_debounce_if #(.NUM_KEYS(NK)) kif ();

    de2_115_key_debounce #(
        .NUM_KEYS        (NK),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CNT_W           (26)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (kif.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       at;
        logic [3:0] pr;
        logic [3:0] rl;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every strobe the DUT emits must match the oldest expected event.
    always @(negedge clk) begin
        if ((kif.press_pulse | kif.release_pulse) != 4'h0) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", {24'h0, kif.press_pulse, kif.release_pulse}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("pulse_cycle", cyc, mon_e.at);
                check_val("press_mask", {28'h0, kif.press_pulse}, {28'h0, mon_e.pr});
                check_val("release_mask", {28'h0, kif.release_pulse}, {28'h0, mon_e.rl});
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] pr, input logic [3:0] rl);
        @(negedge clk);
        kif.key_raw = v;
        if ((pr | rl) != 4'h0) exp_q.push_back('{cyc + DEB + 3, pr, rl});
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_key_out"}, {28'h0, kif.key_out}, 32'hF);
        check_val({tag, "_press"}, {28'h0, kif.press_pulse}, 32'h0);
        check_val({tag, "_release"}, {28'h0, kif.release_pulse}, 32'h0);
        check_val({tag, "_long"}, {28'h0, kif.long_press}, 32'h0);
    endtask

    initial begin
        kif.key_raw = 4'hF;
        reset_n     = 1'b0;
        wait_n(3);
        check_idle("reset");
        @(negedge clk);
        reset_n = 1'b1;
        wait_n(100);
        check_idle("idle100");

        // single press and release on key 0
        drive(4'hE, 4'h1, 4'h0);
        wait_n(10);
        check_val("k0_before_accept", {28'h0, kif.key_out}, 32'hF);
        wait_n(1);
        check_val("k0_accepted", {28'h0, kif.key_out}, 32'hE);
        wait_n(20);
        drive(4'hF, 4'h0, 4'h1);
        wait_n(10);
        check_val("k0_before_release", {28'h0, kif.key_out}, 32'hE);
        wait_n(1);
        check_val("k0_released", {28'h0, kif.key_out}, 32'hF);
        wait_n(5);

        // bouncing key 1: 5 low, 3 high, never accepted
        for (int i = 0; i < 4; i++) begin
            drive(4'hD, 4'h0, 4'h0);
            wait_n(4);
            drive(4'hF, 4'h0, 4'h0);
            wait_n(2);
        end
        wait_n(20);
        check_val("k1_bounce_rejected", {28'h0, kif.key_out}, 32'hF);

        // long press on key 2 with a short release glitch
        drive(4'hB, 4'h4, 4'h0);
        wait_n(42);
        check_val("k2_long_early", {28'h0, kif.long_press}, 32'h0);
        wait_n(1);
        check_val("k2_long_set", {28'h0, kif.long_press}, 32'h4);
        wait_n(17);
        drive(4'hF, 4'h0, 4'h0);
        wait_n(3);
        drive(4'hB, 4'h0, 4'h0);
        wait_n(15);
        check_val("k2_glitch_long", {28'h0, kif.long_press}, 32'h4);
        check_val("k2_glitch_key", {28'h0, kif.key_out}, 32'hB);
        drive(4'hF, 4'h0, 4'h4);
        wait_n(10);
        check_val("k2_long_before_rel", {28'h0, kif.long_press}, 32'h4);
        wait_n(1);
        check_val("k2_long_cleared", {28'h0, kif.long_press}, 32'h0);
        check_val("k2_released", {28'h0, kif.key_out}, 32'hF);
        wait_n(5);

        // simultaneous press of all keys, partial release
        drive(4'h0, 4'hF, 4'h0);
        wait_n(20);
        check_val("all_pressed", {28'h0, kif.key_out}, 32'h0);
        drive(4'h5, 4'h0, 4'h5);
        wait_n(15);
        check_val("k02_released", {28'h0, kif.key_out}, 32'h5);
        drive(4'hF, 4'h0, 4'hA);
        wait_n(15);
        check_val("all_released", {28'h0, kif.key_out}, 32'hF);

        // reset while key 0 is held in PRESSED
        drive(4'hE, 4'h1, 4'h0);
        wait_n(20);
        check_val("k0_held", {28'h0, kif.key_out}, 32'hE);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle("midreset");
        wait_n(3);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back('{cyc + DEB + 3, 4'h1, 4'h0});
        wait_n(20);
        check_val("k0_after_reset", {28'h0, kif.key_out}, 32'hE);
        drive(4'hF, 4'h0, 4'h1);
        wait_n(20);
        check_val("final_key_out", {28'h0, kif.key_out}, 32'hF);
        check_val("events_pending", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
